// File: rtl/vme_wr_axi_bridge_if.sv
// Bundles the VME write command/data/ack signals and the AXI4 AW/W/B write channels.
// master: the bridge side; slave: the store plus memory interconnect side.
interface vme_wr_axi_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 8
);
  logic                  io_vme_wr_cmd_ready;
  logic                  io_vme_wr_cmd_valid;
  logic [ADDR_W-1:0]     io_vme_wr_cmd_bits_addr;
  logic [LEN_W-1:0]      io_vme_wr_cmd_bits_len;
  logic                  io_vme_wr_data_ready;
  logic                  io_vme_wr_data_valid;
  logic [DATA_W-1:0]     io_vme_wr_data_bits_data;
  logic                  io_vme_wr_ack;
  logic                  m_axi_awvalid;
  logic                  m_axi_awready;
  logic [ADDR_W-1:0]     m_axi_awaddr;
  logic [7:0]            m_axi_awlen;
  logic [2:0]            m_axi_awsize;
  logic [1:0]            m_axi_awburst;
  logic [3:0]            m_axi_awid;
  logic                  m_axi_wvalid;
  logic                  m_axi_wready;
  logic [DATA_W-1:0]     m_axi_wdata;
  logic [DATA_W/8-1:0]   m_axi_wstrb;
  logic                  m_axi_wlast;
  logic                  m_axi_bvalid;
  logic                  m_axi_bready;
  logic [1:0]            m_axi_bresp;

  modport master (
    output io_vme_wr_cmd_ready, io_vme_wr_data_ready, io_vme_wr_ack,
    input  io_vme_wr_cmd_valid, io_vme_wr_cmd_bits_addr, io_vme_wr_cmd_bits_len,
    input  io_vme_wr_data_valid, io_vme_wr_data_bits_data,
    output m_axi_awvalid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awid,
    input  m_axi_awready,
    output m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast,
    input  m_axi_wready,
    input  m_axi_bvalid, m_axi_bresp,
    output m_axi_bready
  );

  modport slave (
    input  io_vme_wr_cmd_ready, io_vme_wr_data_ready, io_vme_wr_ack,
    output io_vme_wr_cmd_valid, io_vme_wr_cmd_bits_addr, io_vme_wr_cmd_bits_len,
    output io_vme_wr_data_valid, io_vme_wr_data_bits_data,
    input  m_axi_awvalid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awid,
    output m_axi_awready,
    input  m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast,
    output m_axi_wready,
    output m_axi_bvalid, m_axi_bresp,
    input  m_axi_bready
  );
endinterface

// File: rtl/vme_wr_axi_bridge.sv
// Converts one VME write burst at a time into AXI4 AW/W/B transactions, acking on B.
// Optional macro VME_WR_BRESP_CHK_EN adds a sticky error flag and first-failing address.
module vme_wr_axi_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 8,
  parameter int AXI_ID = 0
) (
  input  logic                clock,
  input  logic                reset,
  vme_wr_axi_bridge_if.master bus
`ifdef VME_WR_BRESP_CHK_EN
  ,
  output logic                io_err,
  output logic [ADDR_W-1:0]   io_err_addr
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, RESP = 2'd3} state_t;

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1'b1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic                awvalid_q, awvalid_d;

  logic in_data_s;
  logic wlast_s;
  logic w_fire_s;
  logic b_fire_s;

  assign in_data_s = (state_q == DATA);
  assign wlast_s   = in_data_s & (cnt_q == len_q);
  assign w_fire_s  = bus.m_axi_wvalid & bus.m_axi_wready;
  // bready is only high in RESP, so a bvalid coinciding with the last W beat waits a cycle
  assign b_fire_s  = (state_q == RESP) & bus.m_axi_bvalid;

  assign bus.io_vme_wr_cmd_ready  = (state_q == IDLE);
  assign bus.io_vme_wr_data_ready = in_data_s & bus.m_axi_wready;
  assign bus.io_vme_wr_ack        = b_fire_s;
  assign bus.m_axi_awvalid        = awvalid_q;
  assign bus.m_axi_awaddr         = addr_q;
  assign bus.m_axi_awlen          = 8'(len_q);
  assign bus.m_axi_awsize         = 3'($clog2(DATA_W / 8));
  assign bus.m_axi_awburst        = 2'b01;
  assign bus.m_axi_awid           = 4'(AXI_ID);
  assign bus.m_axi_wvalid         = in_data_s & bus.io_vme_wr_data_valid;
  assign bus.m_axi_wdata          = bus.io_vme_wr_data_bits_data;
  assign bus.m_axi_wstrb          = '1;
  assign bus.m_axi_wlast          = wlast_s;
  assign bus.m_axi_bready         = (state_q == RESP);

  // Next-state logic for the burst FSM and its command/counter registers.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    awvalid_d = awvalid_q;
    case (state_q)
      IDLE: begin
        if (bus.io_vme_wr_cmd_valid) begin
          addr_d    = bus.io_vme_wr_cmd_bits_addr;
          len_d     = bus.io_vme_wr_cmd_bits_len;
          cnt_d     = '0;
          awvalid_d = 1'b1;
          state_d   = ADDR;
        end else begin
          state_d   = IDLE;
        end
      end
      ADDR: begin
        if (bus.m_axi_awready) begin
          awvalid_d = 1'b0;
          state_d   = DATA;
        end else begin
          state_d   = ADDR;
        end
      end
      DATA: begin
        if (w_fire_s) begin
          // The counter holds on the last beat so len=all-ones never wraps
          if (wlast_s) begin
            state_d = RESP;
          end else begin
            cnt_d   = cnt_q + LEN_ONE;
          end
        end else begin
          state_d = DATA;
        end
      end
      RESP: begin
        if (bus.m_axi_bvalid) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d   = IDLE;
        awvalid_d = 1'b0;
      end
    endcase
  end

  // Burst FSM state and command registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      awvalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      awvalid_q <= awvalid_d;
    end
  end

`ifdef VME_WR_BRESP_CHK_EN
  logic              err_q, err_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;

  // Sticky error flag; only the first failing burst's address is kept.
  always_comb begin
    err_d      = err_q;
    err_addr_d = err_addr_q;
    if (b_fire_s && (bus.m_axi_bresp != 2'b00) && !err_q) begin
      err_d      = 1'b1;
      err_addr_d = addr_q;
    end else begin
      err_d      = err_q;
    end
  end

  // Error status registers, cleared only by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign io_err      = err_q;
  assign io_err_addr = err_addr_q;
`else
  logic unused_bresp_s;
  assign unused_bresp_s = ^bus.m_axi_bresp;
`endif

endmodule

// File: tb/tb_vme_wr_axi_bridge.sv
// Directed self-checking bench for vme_wr_axi_bridge; define VME_WR_BRESP_CHK_EN to cover the error flag.
module tb_vme_wr_axi_bridge;
  logic clock;
  logic reset;
  int   n_tests;
  int   n_fail;
  int   lat;

  vme_wr_axi_bridge_if #(.ADDR_W(32), .DATA_W(64), .LEN_W(8)) bus ();

`ifdef VME_WR_BRESP_CHK_EN
  logic        io_err;
  logic [31:0] io_err_addr;
`endif

  vme_wr_axi_bridge #(.ADDR_W(32), .DATA_W(64), .LEN_W(8), .AXI_ID(0)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
`ifdef VME_WR_BRESP_CHK_EN
    ,
    .io_err      (io_err),
    .io_err_addr (io_err_addr)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(negedge clock);
  endtask

  // One burst through the bridge; checks every cycle and returns the ack cycle relative to the cmd handshake.
  task automatic run_burst(input logic [31:0] addr, input logic [7:0] len, input logic [63:0] base,
                           input int aw_delay, input int b_delay, input bit toggle, input bit early_b,
                           input bit cmd_in_resp, input logic [1:0] resp, output int ack_lat);
    int  k;
    int  t;
    int  guard;
    logic wr;
    bus.io_vme_wr_cmd_valid      = 1'b1;
    bus.io_vme_wr_cmd_bits_addr  = addr;
    bus.io_vme_wr_cmd_bits_len   = len;
    bus.io_vme_wr_data_valid     = 1'b1;
    bus.io_vme_wr_data_bits_data = base;
    bus.m_axi_awready            = 1'b0;
    bus.m_axi_wready             = 1'b1;
    bus.m_axi_bvalid             = 1'b0;
    #1;
    check_eq("cmd_ready_idle", 64'(bus.io_vme_wr_cmd_ready), 64'd1);
    check_eq("awvalid_idle", 64'(bus.m_axi_awvalid), 64'd0);
    check_eq("data_ready_idle", 64'(bus.io_vme_wr_data_ready), 64'd0);
    next_cyc();
    t = 1;
    bus.io_vme_wr_cmd_valid = 1'b0;
    for (int d = 0; d < aw_delay; d++) begin
      #1;
      check_eq("awvalid_hold", 64'(bus.m_axi_awvalid), 64'd1);
      check_eq("awaddr_hold", 64'(bus.m_axi_awaddr), 64'(addr));
      check_eq("data_ready_addr", 64'(bus.io_vme_wr_data_ready), 64'd0);
      check_eq("wvalid_addr", 64'(bus.m_axi_wvalid), 64'd0);
      check_eq("cmd_ready_addr", 64'(bus.io_vme_wr_cmd_ready), 64'd0);
      next_cyc();
      t++;
    end
    bus.m_axi_awready = 1'b1;
    #1;
    check_eq("awvalid", 64'(bus.m_axi_awvalid), 64'd1);
    check_eq("awaddr", 64'(bus.m_axi_awaddr), 64'(addr));
    check_eq("awlen", 64'(bus.m_axi_awlen), 64'(len));
    check_eq("awsize", 64'(bus.m_axi_awsize), 64'd3);
    check_eq("awburst", 64'(bus.m_axi_awburst), 64'd1);
    check_eq("awid", 64'(bus.m_axi_awid), 64'd0);
    check_eq("wvalid_addr", 64'(bus.m_axi_wvalid), 64'd0);
    next_cyc();
    t++;
    bus.m_axi_awready = 1'b0;
    k = 0;
    guard = 0;
    while (k <= int'(len) && guard < 1024) begin
      wr = toggle ? (guard % 2 == 0) : 1'b1;
      bus.m_axi_wready             = wr;
      bus.io_vme_wr_data_bits_data = base ^ 64'(k);
      bus.m_axi_bvalid             = early_b;
      #1;
      check_eq("wvalid", 64'(bus.m_axi_wvalid), 64'd1);
      check_eq("data_ready_mirror", 64'(bus.io_vme_wr_data_ready), 64'(wr));
      check_eq("wdata", bus.m_axi_wdata, base ^ 64'(k));
      check_eq("wstrb", 64'(bus.m_axi_wstrb), 64'hff);
      check_eq("wlast", 64'(bus.m_axi_wlast), 64'(k == int'(len)));
      check_eq("bready_data", 64'(bus.m_axi_bready), 64'd0);
      check_eq("ack_data", 64'(bus.io_vme_wr_ack), 64'd0);
      check_eq("awvalid_data", 64'(bus.m_axi_awvalid), 64'd0);
      next_cyc();
      t++;
      if (wr) k++;
      guard++;
    end
    if (guard >= 1024) check_eq("w_budget", 64'd0, 64'd1);
    bus.m_axi_wready         = 1'b0;
    bus.io_vme_wr_data_valid = 1'b0;
    bus.m_axi_bvalid         = 1'b0;
    for (int d = 0; d < b_delay; d++) begin
      if (cmd_in_resp) bus.io_vme_wr_cmd_valid = 1'b1;
      #1;
      check_eq("bready_resp", 64'(bus.m_axi_bready), 64'd1);
      check_eq("ack_wait", 64'(bus.io_vme_wr_ack), 64'd0);
      check_eq("cmd_ready_resp", 64'(bus.io_vme_wr_cmd_ready), 64'd0);
      check_eq("wvalid_resp", 64'(bus.m_axi_wvalid), 64'd0);
      next_cyc();
      t++;
    end
    bus.m_axi_bvalid = 1'b1;
    bus.m_axi_bresp  = resp;
    #1;
    check_eq("bready", 64'(bus.m_axi_bready), 64'd1);
    check_eq("ack", 64'(bus.io_vme_wr_ack), 64'd1);
    check_eq("cmd_ready_ack", 64'(bus.io_vme_wr_cmd_ready), 64'd0);
    ack_lat = t;
    next_cyc();
    bus.m_axi_bvalid = 1'b0;
    bus.m_axi_bresp  = 2'b00;
    #1;
    check_eq("ack_pulse_end", 64'(bus.io_vme_wr_ack), 64'd0);
    check_eq("cmd_ready_back", 64'(bus.io_vme_wr_cmd_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    bus.io_vme_wr_cmd_valid      = 1'b0;
    bus.io_vme_wr_cmd_bits_addr  = 32'h0;
    bus.io_vme_wr_cmd_bits_len   = 8'h0;
    bus.io_vme_wr_data_valid     = 1'b0;
    bus.io_vme_wr_data_bits_data = 64'h0;
    bus.m_axi_awready            = 1'b0;
    bus.m_axi_wready             = 1'b0;
    bus.m_axi_bvalid             = 1'b0;
    bus.m_axi_bresp              = 2'b00;
    next_cyc();
    next_cyc();
    #1;
    check_eq("rst_cmd_ready", 64'(bus.io_vme_wr_cmd_ready), 64'd1);
    check_eq("rst_awvalid", 64'(bus.m_axi_awvalid), 64'd0);
    check_eq("rst_wvalid", 64'(bus.m_axi_wvalid), 64'd0);
    check_eq("rst_bready", 64'(bus.m_axi_bready), 64'd0);
    check_eq("rst_ack", 64'(bus.io_vme_wr_ack), 64'd0);
    check_eq("rst_data_ready", 64'(bus.io_vme_wr_data_ready), 64'd0);
    check_eq("rst_awaddr", 64'(bus.m_axi_awaddr), 64'd0);
    check_eq("rst_awlen", 64'(bus.m_axi_awlen), 64'd0);
`ifdef VME_WR_BRESP_CHK_EN
    check_eq("rst_err", 64'(io_err), 64'd0);
`endif
    next_cyc();
    reset = 1'b0;

    // Single beat, bvalid already high during the last W beat
    run_burst(32'h1000, 8'd0, 64'hDEADBEEF_CAFEF00D, 0, 0, 1'b0, 1'b1, 1'b0, 2'b00, lat);
    check_eq("lat_single", 64'(lat), 64'd3);
    // Four beats with wready toggling 1,0,1,0
    run_burst(32'h1100, 8'd3, 64'h1111_2222_3333_4444, 0, 0, 1'b1, 1'b0, 1'b0, 2'b00, lat);
    check_eq("lat_toggle", 64'(lat), 64'd9);
    // awready held off for 5 cycles
    run_burst(32'h1200, 8'd1, 64'h5555_6666_7777_8888, 5, 0, 1'b0, 1'b0, 1'b0, 2'b00, lat);
    check_eq("lat_aw_delay", 64'(lat), 64'd9);
    // Second command raised during RESP with bvalid 3 cycles late
    run_burst(32'h1300, 8'd2, 64'h0123_4567_89AB_CDEF, 0, 3, 1'b0, 1'b0, 1'b1, 2'b00, lat);
    check_eq("lat_b_delay", 64'(lat), 64'd8);
    run_burst(32'h1400, 8'd0, 64'hFEDC_BA98_7654_3210, 0, 0, 1'b0, 1'b0, 1'b0, 2'b00, lat);
    check_eq("lat_second", 64'(lat), 64'd3);
    // Maximum length burst
    run_burst(32'h8000, 8'd255, 64'hA5A5_0000_5A5A_0000, 0, 1, 1'b0, 1'b0, 1'b0, 2'b00, lat);
    check_eq("lat_len255", 64'(lat), 64'd259);

    // Asynchronous reset after two beats of a len=7 burst
    bus.io_vme_wr_cmd_valid      = 1'b1;
    bus.io_vme_wr_cmd_bits_addr  = 32'h3000;
    bus.io_vme_wr_cmd_bits_len   = 8'd7;
    bus.io_vme_wr_data_valid     = 1'b1;
    bus.m_axi_awready            = 1'b1;
    bus.m_axi_wready             = 1'b1;
    next_cyc();
    bus.io_vme_wr_cmd_valid = 1'b0;
    next_cyc();
    next_cyc();
    next_cyc();
    #1;
    check_eq("pre_rst_wvalid", 64'(bus.m_axi_wvalid), 64'd1);
    #1;
    reset = 1'b1;
    #1;
    check_eq("mid_rst_awvalid", 64'(bus.m_axi_awvalid), 64'd0);
    check_eq("mid_rst_wvalid", 64'(bus.m_axi_wvalid), 64'd0);
    check_eq("mid_rst_bready", 64'(bus.m_axi_bready), 64'd0);
    check_eq("mid_rst_ack", 64'(bus.io_vme_wr_ack), 64'd0);
    check_eq("mid_rst_cmd_ready", 64'(bus.io_vme_wr_cmd_ready), 64'd1);
    check_eq("mid_rst_data_ready", 64'(bus.io_vme_wr_data_ready), 64'd0);
    next_cyc();
    reset = 1'b0;
    run_burst(32'h3100, 8'd0, 64'h0F0F_0F0F_F0F0_F0F0, 0, 0, 1'b0, 1'b0, 1'b0, 2'b00, lat);
    check_eq("lat_post_rst", 64'(lat), 64'd3);

`ifdef VME_WR_BRESP_CHK_EN
    check_eq("err_clear_ok", 64'(io_err), 64'd0);
    run_burst(32'h2040, 8'd1, 64'hBAD0_BAD0_BAD0_BAD0, 0, 0, 1'b0, 1'b0, 1'b0, 2'b10, lat);
    check_eq("err_set", 64'(io_err), 64'd1);
    check_eq("err_addr", 64'(io_err_addr), 64'h2040);
    run_burst(32'h5000, 8'd0, 64'h600D_600D_600D_600D, 0, 0, 1'b0, 1'b0, 1'b0, 2'b00, lat);
    check_eq("err_sticky", 64'(io_err), 64'd1);
    run_burst(32'h6000, 8'd0, 64'hBAD1_BAD1_BAD1_BAD1, 0, 0, 1'b0, 1'b0, 1'b0, 2'b11, lat);
    check_eq("err_addr_first", 64'(io_err_addr), 64'h2040);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
